// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg: shared types and constants for the Zorro II autoconfig
// responder of the 8MB FastRAM board.
//   - ac_state_e      : OFFER0..OFFER3 (index = block on offer), DONE
//   - OFF_*           : autoconfig register offsets (ADDR[8:1])
//   - DEF_*           : default manufacturer / product / serial identity
//   - E8_PAGE         : ADDR[23:16] of the autoconfig space ($E8xxxx)
//   - rom_nibble()    : autoconfig nibble ROM contents
//   - base_match()    : ADDR_MATCH bits claimed by a base-address write
package autoconfig_pkg;

  typedef enum logic [2:0] {
    OFFER0 = 3'd0,
    OFFER1 = 3'd1,
    OFFER2 = 3'd2,
    OFFER3 = 3'd3,
    DONE   = 3'd4
  } ac_state_e;

  localparam logic [7:0] E8_PAGE    = 8'hE8;

  localparam logic [7:0] OFF_TYPE   = 8'h00;
  localparam logic [7:0] OFF_PROD   = 8'h02;
  localparam logic [7:0] OFF_FLAGS  = 8'h04;
  localparam logic [7:0] OFF_MFG    = 8'h08;
  localparam logic [7:0] OFF_SERIAL = 8'h10;
  localparam logic [7:0] OFF_ROMVEC = 8'h20;
  localparam logic [7:0] OFF_BASE   = 8'h24;
  localparam logic [7:0] OFF_SHUTUP = 8'h26;

  localparam logic [15:0] DEF_MFG_ID  = 16'h07DB;
  localparam logic [7:0]  DEF_PROD_ID = 8'd69;
  localparam logic [15:0] DEF_SERIAL  = 16'd421;

  // Everything except the first two type nibbles and the ROM vector is
  // stored inverted, as the Zorro II autoconfig protocol requires.
  function automatic logic [3:0] rom_nibble(input logic [7:0]  off,
                                            input logic [15:0] mfg,
                                            input logic [7:0]  prod,
                                            input logic [15:0] ser);
    case (off)
      OFF_TYPE:             rom_nibble = 4'hE;  // Zorro II, memory
      OFF_TYPE + 8'd1:      rom_nibble = 4'h6;  // 2MB
      OFF_PROD:             rom_nibble = ~prod[7:4];
      OFF_PROD + 8'd1:      rom_nibble = ~prod[3:0];
      OFF_FLAGS:            rom_nibble = ~4'h8;
      OFF_FLAGS + 8'd1:     rom_nibble = ~4'h0;
      OFF_MFG:              rom_nibble = ~mfg[15:12];
      OFF_MFG + 8'd1:       rom_nibble = ~mfg[11:8];
      OFF_MFG + 8'd2:       rom_nibble = ~mfg[7:4];
      OFF_MFG + 8'd3:       rom_nibble = ~mfg[3:0];
      OFF_SERIAL:           rom_nibble = ~ser[15:12];
      OFF_SERIAL + 8'd1:    rom_nibble = ~ser[11:8];
      OFF_SERIAL + 8'd2:    rom_nibble = ~ser[7:4];
      OFF_SERIAL + 8'd3:    rom_nibble = ~ser[3:0];
      OFF_ROMVEC,
      OFF_ROMVEC + 8'd1:    rom_nibble = 4'h0;
      default:              rom_nibble = 4'hF;
    endcase
  endfunction

  // Base nibble 2/4/6/8 selects the 2MB block at $200000/$400000/...
  function automatic logic [7:0] base_match(input logic [3:0] nib);
    case (nib)
      4'h2:    base_match = 8'h03;
      4'h4:    base_match = 8'h0C;
      4'h6:    base_match = 8'h30;
      4'h8:    base_match = 8'hC0;
      default: base_match = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/autoconfig_if.sv
// autoconfig_if: 68000 bus signals seen by the autoconfig responder.
//   ASn, UDSn, RWn : raw bus strobes (asynchronous to CLK)
//   ADDR[23:1]     : address bus
//   DBUS_IN        : D[15:12] as driven by the CPU
//   DBUS_OUT       : read nibble for D[15:12]
//   DBUS_OE        : output enable for DBUS_OUT
// Modports: master (CPU side), slave (responder side).
interface autoconfig_if;
  logic        ASn;
  logic        UDSn;
  logic        RWn;
  logic [23:1] ADDR;
  logic [3:0]  DBUS_IN;
  logic [3:0]  DBUS_OUT;
  logic        DBUS_OE;

  modport master (output ASn, UDSn, RWn, ADDR, DBUS_IN,
                  input  DBUS_OUT, DBUS_OE);
  modport slave  (input  ASn, UDSn, RWn, ADDR, DBUS_IN,
                  output DBUS_OUT, DBUS_OE);
endinterface

// File: rtl/autoconfig_bus_sync.sv
// bus_sync: two-flop synchroniser with edge detection for active-low
// strobes. All flops reset to 1 (strobe idle).
//   CLK, RESETn : clock, asynchronous active-low reset
//   d_in        : raw asynchronous inputs
//   q_out       : synchronised level
//   rise, fall  : one-cycle pulses on synchronised 0->1 / 1->0
module bus_sync #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] d_p0, d_p1, d_p2;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      d_p0 <= '1;
      d_p1 <= '1;
      d_p2 <= '1;
    end else begin
      // p0/p1: metastability chain; p2: previous synced value for edges
      d_p0 <= d_in;
      d_p1 <= d_p0;
      d_p2 <= d_p1;
    end
  end

  assign q_out = d_p1;
  assign rise  = d_p1 & ~d_p2;
  assign fall  = ~d_p1 & d_p2;
endmodule

// File: rtl/autoconfig_ctrl.sv
// autoconfig_ctrl: Zorro II autoconfig responder for the 8MB FastRAM board.
// Presents the nibble ROM at $E80000, accepts base-address (offset $24) and
// shutup (offset $26) writes, offering the memory as four 2MB blocks.
//   CLK, RESETn : bus clock, asynchronous active-low reset
//   CFGINn      : chain enable from previous board (low = our turn)
//   bus         : 68000 strobes, address, data nibble (autoconfig_if.slave)
//   CFGOUTn     : chain enable to next board
//   ADDR_MATCH  : bit n set = $200000 + n*1MB belongs to this board
//   CONFIGURED  : at least one block assigned
// Build option: define CDTV_EN to stay silent until the CDTV DMAC (first
// board in the chain) has been given its base address.
module autoconfig_ctrl
  import autoconfig_pkg::*;
#(
  parameter logic [15:0] MFG_ID  = DEF_MFG_ID,
  parameter logic [7:0]  PROD_ID = DEF_PROD_ID,
  parameter logic [15:0] SERIAL  = DEF_SERIAL
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          CFGINn,
  autoconfig_if.slave   bus,
  output logic          CFGOUTn,
  output logic [7:0]    ADDR_MATCH,
  output logic          CONFIGURED
);
  ac_state_e  state, state_nx;
  logic [7:0] match_nx;
  logic       configured_nx;
  logic       cfgin_r;
  logic [3:0] dbus_out_r;

  logic [1:0] strb_sync, strb_rise, strb_fall;
  logic       as_rise, uds_fall;
  logic       e8_hit, win, wr_qual, wr_base, wr_shut;
  logic [7:0] off;
  logic       unused_bits;

  bus_sync #(.WIDTH(2)) u_sync (
    .CLK    (CLK),
    .RESETn (RESETn),
    .d_in   ({bus.ASn, bus.UDSn}),
    .q_out  (strb_sync),
    .rise   (strb_rise),
    .fall   (strb_fall)
  );

  assign as_rise  = strb_rise[1];
  assign uds_fall = strb_fall[0] & ~strb_sync[1];

  assign off    = bus.ADDR[8:1];
  assign e8_hit = (bus.ADDR[23:16] == E8_PAGE);

`ifdef CDTV_EN
  logic dmac_seen;

  // A base write while our chain input is still high is the DMAC's.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      dmac_seen <= 1'b0;
    else if (uds_fall && e8_hit && !bus.RWn && off == OFF_BASE && cfgin_r)
      dmac_seen <= 1'b1;
  end

  assign win = e8_hit & ~cfgin_r & (state != DONE) & dmac_seen;
`else
  assign win = e8_hit & ~cfgin_r & (state != DONE);
`endif

  assign wr_qual = uds_fall & win & ~bus.RWn;
  assign wr_base = wr_qual & (off == OFF_BASE);
  assign wr_shut = wr_qual & (off == OFF_SHUTUP);

  // Raw strobes here: the enable must follow UDSn without sync delay.
  assign bus.DBUS_OE  = RESETn & win & bus.RWn & ~bus.ASn & ~bus.UDSn;
  assign bus.DBUS_OUT = dbus_out_r;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= OFFER0;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    match_nx      = ADDR_MATCH;
    configured_nx = CONFIGURED;
    if (wr_base) begin
      // Unknown base nibbles still consume the offer.
      match_nx      = ADDR_MATCH | base_match(bus.DBUS_IN);
      configured_nx = 1'b1;
      case (state)
        OFFER0:  state_nx = OFFER1;
        OFFER1:  state_nx = OFFER2;
        OFFER2:  state_nx = OFFER3;
        OFFER3:  state_nx = DONE;
        default: state_nx = state;
      endcase
    end else if (wr_shut) begin
      state_nx = DONE;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ADDR_MATCH <= 8'h00;
      CONFIGURED <= 1'b0;
      cfgin_r    <= 1'b1;
      CFGOUTn    <= 1'b1;
      dbus_out_r <= 4'hF;
    end else begin
      ADDR_MATCH <= match_nx;
      CONFIGURED <= configured_nx;
      // Chain signals only move at the end of a bus cycle.
      if (as_rise) begin
        cfgin_r <= CFGINn;
        CFGOUTn <= (state != DONE);
      end
      if (win && bus.RWn)
        dbus_out_r <= rom_nibble(off, MFG_ID, PROD_ID, SERIAL);
    end
  end

  assign unused_bits = strb_rise[0] ^ strb_fall[1] ^ (^bus.ADDR[15:9]);

endmodule

// File: tb/tb_autoconfig_ctrl.sv
// tb_autoconfig_ctrl: self-checking bench for autoconfig_ctrl. Each bus
// cycle is run by bus_cycle(), which returns what the bus saw; the test
// tasks compare those observations against constants or against a
// transaction-level model of the board (offer count, claimed blocks,
// chain flags) and a ROM image built from the board identity.
module tb_autoconfig_ctrl;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       CFGINn;
  logic       CFGOUTn;
  logic [7:0] ADDR_MATCH;
  logic       CONFIGURED;

  autoconfig_if bus ();

  autoconfig_ctrl dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .CFGINn     (CFGINn),
    .bus        (bus),
    .CFGOUTn    (CFGOUTn),
    .ADDR_MATCH (ADDR_MATCH),
    .CONFIGURED (CONFIGURED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] dout;
    logic       oe_pre;
    logic       oe_low;
    logic       oe_post;
    logic [7:0] m2;
    logic [7:0] m3;
    logic       c3;
    logic       co2;
    logic       co3;
  } obs_t;

  // ---------------- reference model ----------------
  logic [3:0] rom_m [256];
  logic       m_cfgin, m_done, m_conf, m_cfgout, m_dmac;
  int         m_cnt;
  logic [7:0] m_match;

  task automatic build_rom();
    logic [15:0] mfg, ser;
    logic [7:0]  prod;
    mfg  = 16'h07DB;
    prod = 8'd69;
    ser  = 16'd421;
    for (int i = 0; i < 256; i++) rom_m[i] = 4'hF;
    rom_m[8'h00] = 4'hE;
    rom_m[8'h01] = 4'h6;
    rom_m[8'h02] = ~prod[7:4];
    rom_m[8'h03] = ~prod[3:0];
    rom_m[8'h04] = ~4'h8;
    rom_m[8'h05] = ~4'h0;
    for (int i = 0; i < 4; i++) begin
      rom_m[8'h08 + i] = ~4'((mfg >> (12 - 4 * i)) & 16'hF);
      rom_m[8'h10 + i] = ~4'((ser >> (12 - 4 * i)) & 16'hF);
    end
    rom_m[8'h20] = 4'h0;
    rom_m[8'h21] = 4'h0;
  endtask

  task automatic model_reset();
    m_cfgin  = 1'b1;
    m_done   = 1'b0;
    m_conf   = 1'b0;
    m_cfgout = 1'b1;
    m_dmac   = 1'b0;
    m_cnt    = 0;
    m_match  = 8'h00;
  endtask

  // One complete bus cycle at transaction level.
  task automatic model_step(input logic [7:0] page, input logic [7:0] off,
                            input logic rw, input logic [3:0] din,
                            input logic cfgin, output logic answered);
    answered = (page == 8'hE8) && !m_cfgin && !m_done;
`ifdef CDTV_EN
    answered = answered && m_dmac;
    if (page == 8'hE8 && !rw && off == 8'h24 && m_cfgin) m_dmac = 1'b1;
`endif
    if (answered && !rw) begin
      if (off == 8'h24) begin
        if (din == 4'd2 || din == 4'd4 || din == 4'd6 || din == 4'd8)
          m_match = m_match | 8'(8'h03 << (int'(din) - 2));
        m_conf = 1'b1;
        m_cnt++;
        if (m_cnt == 4) m_done = 1'b1;
      end else if (off == 8'h26) begin
        m_done = 1'b1;
      end
    end
    m_cfgin  = cfgin;
    m_cfgout = !m_done;
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_cycle(input logic [7:0] page, input logic [7:0] off,
                           input logic rw, input logic [3:0] din,
                           input logic cfgin, output obs_t o);
    tick();
    bus.ADDR    = {page, 7'h00, off};
    bus.RWn     = rw;
    bus.DBUS_IN = din;
    CFGINn      = cfgin;
    bus.ASn     = 1'b0;
    tick();
    o.oe_pre = bus.DBUS_OE;
    bus.UDSn = 1'b0;
    tick();
    tick();
    o.m2 = ADDR_MATCH;
    tick();
    o.m3 = ADDR_MATCH;
    o.c3 = CONFIGURED;
    tick();
    o.dout   = bus.DBUS_OUT;
    o.oe_low = bus.DBUS_OE;
    bus.UDSn = 1'b1;
    tick();
    o.oe_post = bus.DBUS_OE;
    bus.ASn   = 1'b1;
    tick();
    tick();
    o.co2 = CFGOUTn;
    tick();
    o.co3 = CFGOUTn;
    tick();
  endtask

  task automatic hw_reset();
    bus.ASn  = 1'b1;
    bus.UDSn = 1'b1;
    bus.RWn  = 1'b1;
    RESETn   = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
    tick();
    model_reset();
  endtask

  // Reset plus the ignored first cycle; that cycle is an offset-24 write so
  // that a CDTV_EN build also sees its DMAC configured.
  task automatic do_reset(input logic cfgin);
    obs_t o;
    logic ans;
    hw_reset();
    model_step(8'hE8, 8'h24, 1'b0, 4'h2, cfgin, ans);
    bus_cycle(8'hE8, 8'h24, 1'b0, 4'h2, cfgin, o);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESETn = 1'b0;
    tick();
    n_vec += 5;
    if (bus.DBUS_OUT !== 4'hF) begin n_bad++; $display("FAIL reset_dout: got %h want F", bus.DBUS_OUT); end
    if (bus.DBUS_OE !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", bus.DBUS_OE); end
    if (CFGOUTn !== 1'b1) begin n_bad++; $display("FAIL reset_cfgout: got %b want 1", CFGOUTn); end
    if (ADDR_MATCH !== 8'h00) begin n_bad++; $display("FAIL reset_match: got %h want 00", ADDR_MATCH); end
    if (CONFIGURED !== 1'b0) begin n_bad++; $display("FAIL reset_configured: got %b want 0", CONFIGURED); end
  endtask

  task automatic test_reset_read();
    logic [7:0] offs [4];
    logic [3:0] exp  [4];
    obs_t o;
    offs = '{8'h00, 8'h01, 8'h08, 8'h0B};
    exp  = '{4'hE, 4'h6, 4'hF, 4'h4};
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      bus_cycle(8'hE8, offs[i], 1'b1, 4'h0, 1'b0, o);
      n_vec += 4;
      if (o.dout !== exp[i]) begin n_bad++; $display("FAIL read_dout[%h]: got %h want %h", offs[i], o.dout, exp[i]); end
      if (o.oe_pre !== 1'b0) begin n_bad++; $display("FAIL read_oe_pre[%h]: got %b want 0", offs[i], o.oe_pre); end
      if (o.oe_low !== 1'b1) begin n_bad++; $display("FAIL read_oe_low[%h]: got %b want 1", offs[i], o.oe_low); end
      if (o.oe_post !== 1'b0) begin n_bad++; $display("FAIL read_oe_post[%h]: got %b want 0", offs[i], o.oe_post); end
    end
  endtask

  task automatic test_full_config();
    logic [7:0] exp_m [4];
    obs_t o;
    exp_m = '{8'h03, 8'h0F, 8'h3F, 8'hFF};
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      bus_cycle(8'hE8, 8'h24, 1'b0, 4'(2 * k + 2), 1'b0, o);
      n_vec += 4;
      if (o.m2 !== (k == 0 ? 8'h00 : exp_m[k == 0 ? 0 : k - 1])) begin n_bad++; $display("FAIL cfg_latency[%0d]: got %h early", k, o.m2); end
      if (o.m3 !== exp_m[k]) begin n_bad++; $display("FAIL cfg_match[%0d]: got %h want %h", k, o.m3, exp_m[k]); end
      if (o.c3 !== 1'b1) begin n_bad++; $display("FAIL cfg_configured[%0d]: got %b want 1", k, o.c3); end
      if (o.co3 !== (k == 3 ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL cfg_cfgout[%0d]: got %b", k, o.co3); end
    end
    n_vec++;
    if (o.co2 !== 1'b1) begin n_bad++; $display("FAIL cfg_chain_latency: got %b want 1 at 2 CLK", o.co2); end
    bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, 1'b0, o);
    n_vec++;
    if (o.oe_low !== 1'b0) begin n_bad++; $display("FAIL cfg_done_read_oe: got %b want 0", o.oe_low); end
  endtask

  task automatic test_shutup();
    obs_t o;
    do_reset(1'b0);
    bus_cycle(8'hE8, 8'h24, 1'b0, 4'h2, 1'b0, o);
    bus_cycle(8'hE8, 8'h26, 1'b0, 4'h4, 1'b0, o);
    n_vec += 2;
    if (o.m3 !== 8'h03) begin n_bad++; $display("FAIL shutup_match: got %h want 03", o.m3); end
    if (o.co3 !== 1'b0) begin n_bad++; $display("FAIL shutup_cfgout: got %b want 0", o.co3); end
    bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, 1'b0, o);
    n_vec++;
    if (o.oe_low !== 1'b0) begin n_bad++; $display("FAIL shutup_read_oe: got %b want 0", o.oe_low); end
  endtask

  task automatic test_chain_gating();
    obs_t o;
    do_reset(1'b1);
    for (int k = 0; k < 4; k++)
      bus_cycle(8'hE8, 8'h24, 1'b0, 4'(2 * k + 2), 1'b1, o);
    bus_cycle(8'hE8, 8'h26, 1'b0, 4'h0, 1'b1, o);
    n_vec += 3;
    if (ADDR_MATCH !== 8'h00) begin n_bad++; $display("FAIL gate_match: got %h want 00", ADDR_MATCH); end
    if (CONFIGURED !== 1'b0) begin n_bad++; $display("FAIL gate_configured: got %b want 0", CONFIGURED); end
    if (CFGOUTn !== 1'b1) begin n_bad++; $display("FAIL gate_cfgout: got %b want 1", CFGOUTn); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick();
    bus.ADDR    = {8'hE8, 7'h00, 8'h24};
    bus.RWn     = 1'b0;
    bus.DBUS_IN = 4'h2;
    CFGINn      = 1'b0;
    bus.ASn     = 1'b0;
    tick();
    bus.UDSn = 1'b0;
    tick();
    RESETn = 1'b0;
    #1;
    n_vec += 4;
    if (ADDR_MATCH !== 8'h00) begin n_bad++; $display("FAIL mid_match: got %h want 00", ADDR_MATCH); end
    if (CFGOUTn !== 1'b1) begin n_bad++; $display("FAIL mid_cfgout: got %b want 1", CFGOUTn); end
    if (bus.DBUS_OUT !== 4'hF) begin n_bad++; $display("FAIL mid_dout: got %h want F", bus.DBUS_OUT); end
    if (CONFIGURED !== 1'b0) begin n_bad++; $display("FAIL mid_configured: got %b want 0", CONFIGURED); end
    tick();
    tick();
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.UDSn = 1'b1;
    tick();
    bus.ASn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_vec += 2;
    if (ADDR_MATCH !== 8'h00) begin n_bad++; $display("FAIL mid_after_match: got %h want 00", ADDR_MATCH); end
    if (CONFIGURED !== 1'b0) begin n_bad++; $display("FAIL mid_after_configured: got %b want 0", CONFIGURED); end
  endtask

  task automatic test_random();
    logic [7:0] offs [19];
    obs_t       o;
    logic [7:0] page, off;
    logic       rw, cfgin, ans, prev_co;
    logic [3:0] din;
    offs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08, 8'h09, 8'h0A,
             8'h0B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h24, 8'h26, 8'h3C};
    do_reset(1'b0);
    for (int n = 0; n < 60; n++) begin
      if (m_done && $urandom_range(0, 2) == 0) do_reset(1'b0);
      page  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hE8;
      off   = offs[$urandom_range(0, 18)];
      if ($urandom_range(0, 9) == 0) off = 8'($urandom_range(0, 255));
      rw    = 1'($urandom_range(0, 1));
      din   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(2 * $urandom_range(1, 4));
      cfgin = ($urandom_range(0, 5) == 0);
      prev_co = m_cfgout;
      model_step(page, off, rw, din, cfgin, ans);
      bus_cycle(page, off, rw, din, cfgin, o);
      n_vec += 5;
      if (o.oe_low !== (ans && rw)) begin n_bad++; $display("FAIL rnd_oe[%0d]: got %b want %b", n, o.oe_low, ans && rw); end
      if (o.m3 !== m_match) begin n_bad++; $display("FAIL rnd_match[%0d]: got %h want %h", n, o.m3, m_match); end
      if (o.c3 !== m_conf) begin n_bad++; $display("FAIL rnd_configured[%0d]: got %b want %b", n, o.c3, m_conf); end
      if (o.co2 !== prev_co) begin n_bad++; $display("FAIL rnd_cfgout_early[%0d]: got %b want %b", n, o.co2, prev_co); end
      if (o.co3 !== m_cfgout) begin n_bad++; $display("FAIL rnd_cfgout[%0d]: got %b want %b", n, o.co3, m_cfgout); end
      if (ans && rw) begin
        n_vec++;
        if (o.dout !== rom_m[off]) begin n_bad++; $display("FAIL rnd_dout[%0d] off %h: got %h want %h", n, off, o.dout, rom_m[off]); end
      end
    end
  endtask

`ifdef CDTV_EN
  task automatic test_cdtv();
    obs_t o;
    hw_reset();
    bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, 1'b0, o);
    bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, 1'b0, o);
    n_vec++;
    if (o.oe_low !== 1'b0) begin n_bad++; $display("FAIL cdtv_no_dmac_oe: got %b want 0", o.oe_low); end
    hw_reset();
    bus_cycle(8'hE8, 8'h24, 1'b0, 4'h2, 1'b1, o);
    bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, 1'b0, o);
    n_vec++;
    if (o.oe_low !== 1'b0) begin n_bad++; $display("FAIL cdtv_gated_oe: got %b want 0", o.oe_low); end
    bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, 1'b0, o);
    n_vec += 2;
    if (o.oe_low !== 1'b1) begin n_bad++; $display("FAIL cdtv_oe: got %b want 1", o.oe_low); end
    if (o.dout !== 4'hE) begin n_bad++; $display("FAIL cdtv_dout: got %h want E", o.dout); end
  endtask
`endif

  initial begin
    bus.ASn     = 1'b1;
    bus.UDSn    = 1'b1;
    bus.RWn     = 1'b1;
    bus.ADDR    = '0;
    bus.DBUS_IN = 4'h0;
    CFGINn      = 1'b1;
    RESETn      = 1'b0;
    build_rom();
    model_reset();
    test_reset();
    test_reset_read();
    test_full_config();
    test_shutup();
    test_chain_gating();
    test_reset_mid();
    test_random();
`ifdef CDTV_EN
    test_cdtv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
